// File: rtl/cwc_trig_pkg.sv
// Shared types and constants for the cwc_trig_seq trigger sequencer.
package cwc_trig_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIRE = 2'd2
    } state_t;

    // Register select field, low two bits of cfg_addr
    localparam logic [1:0] SEL_MASK  = 2'd0;
    localparam logic [1:0] SEL_VALUE = 2'd1;
    localparam logic [1:0] SEL_COUNT = 2'd2;
    localparam logic [1:0] SEL_TMO   = 2'd3;

    // Stage index width; at least one bit so a single-stage build still has a port
    function automatic int unsigned stage_w(input int unsigned stages);
        return (stages > 1) ? $clog2(stages) : 1;
    endfunction

endpackage

// File: rtl/cwc_trig_match.sv
// Combinational mask/value comparator. A zero mask bit makes that probe bit a don't-care.
module cwc_trig_match #(
    parameter int unsigned DW = 32
) (
    input  logic [DW-1:0] probe_i,
    input  logic [DW-1:0] mask_i,
    input  logic [DW-1:0] value_i,
    output logic          hit_o
);

    // Hit when every masked bit of the probe equals the programmed value
    assign hit_o = (((probe_i ^ value_i) & mask_i) == '0);

endmodule

// File: rtl/cwc_trig_seq.sv
// cwc_trig_seq: multi-stage trigger sequencer feeding a one-cycle trig_out pulse into the
// capture hub. Each stage waits for count+1 (not necessarily consecutive) mask/value matches.
// Optional feature: define CWC_TRIG_TIMEOUT_EN to build per-stage timeouts that restart the
// sequence at stage 0 when a stage takes too long.
module cwc_trig_seq
    import cwc_trig_pkg::*;
#(
    parameter int unsigned DW     = 32,
    parameter int unsigned STAGES = 4,
    parameter int unsigned CNT_W  = 16,
    localparam int unsigned AW    = $clog2(STAGES) + 2,
    localparam int unsigned SW    = stage_w(STAGES)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [DW-1:0] probe,
    input  logic          arm,
    input  logic          abort,
    input  logic          cfg_we,
    input  logic [AW-1:0] cfg_addr,
    input  logic [31:0]   cfg_wdata,
    output logic          trig_out,
    output logic          busy,
    output logic          done,
    output logic [SW-1:0] stage
);

    state_t           state_q, state_d;
    logic [SW-1:0]    stage_q, stage_d;
    logic [CNT_W-1:0] occ_q, occ_d;
    logic             trig_out_q, trig_out_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [DW-1:0]    probe_q;
    logic             arm_q;

    logic [DW-1:0]    mask_q  [STAGES];
    logic [DW-1:0]    mask_d  [STAGES];
    logic [DW-1:0]    value_q [STAGES];
    logic [DW-1:0]    value_d [STAGES];
    logic [CNT_W-1:0] count_q [STAGES];
    logic [CNT_W-1:0] count_d [STAGES];
`ifdef CWC_TRIG_TIMEOUT_EN
    logic [CNT_W-1:0] tmo_lim_q [STAGES];
    logic [CNT_W-1:0] tmo_lim_d [STAGES];
    logic [CNT_W-1:0] tmo_q, tmo_d;
    logic [CNT_W-1:0] tmo_inc;
`endif

    logic [SW-1:0]    wr_stage;
    logic [1:0]       wr_sel;
    logic             cfg_wr_en;
    logic             arm_edge;
    logic             hit;
    logic             unused_wdata;

    // Bits of the write word above DW/CNT_W are intentionally dropped
    assign unused_wdata = ^cfg_wdata;

    assign wr_sel    = cfg_addr[1:0];
    assign cfg_wr_en = cfg_we && (state_q == IDLE);
    assign arm_edge  = arm && !arm_q;

    if (STAGES > 1) begin : g_wr_stage
        assign wr_stage = cfg_addr[AW-1:2];
    end else begin : g_wr_stage_one
        assign wr_stage = '0;
    end

    cwc_trig_match #(
        .DW(DW)
    ) u_match (
        .probe_i(probe_q),
        .mask_i (mask_q[stage_q]),
        .value_i(value_q[stage_q]),
        .hit_o  (hit)
    );

    // Configuration register next-state: writes only land while idle
    always_comb begin
        for (int unsigned k = 0; k < STAGES; k++) begin
            mask_d[k]  = mask_q[k];
            value_d[k] = value_q[k];
            count_d[k] = count_q[k];
`ifdef CWC_TRIG_TIMEOUT_EN
            tmo_lim_d[k] = tmo_lim_q[k];
`endif
        end
        if (cfg_wr_en) begin
            case (wr_sel)
                SEL_MASK:  mask_d[wr_stage]  = cfg_wdata[DW-1:0];
                SEL_VALUE: value_d[wr_stage] = cfg_wdata[DW-1:0];
                SEL_COUNT: count_d[wr_stage] = cfg_wdata[CNT_W-1:0];
                default: begin
`ifdef CWC_TRIG_TIMEOUT_EN
                    tmo_lim_d[wr_stage] = cfg_wdata[CNT_W-1:0];
`endif
                end
            endcase
        end
    end

    // Sequencer next-state: occurrence counting, stage advance, fire and abort
    always_comb begin
        state_d = state_q;
        stage_d = stage_q;
        occ_d   = occ_q;
        done_d  = done_q;
`ifdef CWC_TRIG_TIMEOUT_EN
        tmo_d   = tmo_q;
        tmo_inc = (tmo_q == '1) ? tmo_q : tmo_q + 1'b1;
`endif
        case (state_q)
            IDLE: begin
                if (arm_edge) begin
                    state_d = RUN;
                    stage_d = '0;
                    occ_d   = '0;
                    done_d  = 1'b0;
`ifdef CWC_TRIG_TIMEOUT_EN
                    tmo_d   = '0;
`endif
                end
            end
            RUN: begin
                if (hit && (occ_q == count_q[stage_q])) begin
                    // Completion beats a coincident timeout
                    occ_d = '0;
`ifdef CWC_TRIG_TIMEOUT_EN
                    tmo_d = '0;
`endif
                    if (stage_q == SW'(STAGES - 1)) begin
                        state_d = FIRE;
                    end else begin
                        stage_d = stage_q + 1'b1;
                    end
                end else begin
                    if (hit) begin
                        occ_d = (occ_q == '1) ? occ_q : occ_q + 1'b1;
                    end
`ifdef CWC_TRIG_TIMEOUT_EN
                    if ((tmo_lim_q[stage_q] != '0) && (tmo_inc == tmo_lim_q[stage_q])) begin
                        stage_d = '0;
                        occ_d   = '0;
                        tmo_d   = '0;
                    end else begin
                        tmo_d = tmo_inc;
                    end
`endif
                end
            end
            FIRE: begin
                state_d = IDLE;
                stage_d = '0;
                done_d  = 1'b1;
            end
            default: begin
                state_d = IDLE;
                stage_d = '0;
            end
        endcase
        // Abort overrides everything, including a coincident arm edge or a pending fire
        if (abort) begin
            state_d = IDLE;
            stage_d = '0;
            occ_d   = '0;
            done_d  = done_q;
        end
    end

    assign trig_out_d = (state_d == FIRE);
    assign busy_d     = (state_d == RUN);

    // Sequencer state and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            stage_q    <= '0;
            occ_q      <= '0;
            trig_out_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
`ifdef CWC_TRIG_TIMEOUT_EN
            tmo_q      <= '0;
`endif
        end else begin
            state_q    <= state_d;
            stage_q    <= stage_d;
            occ_q      <= occ_d;
            trig_out_q <= trig_out_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
`ifdef CWC_TRIG_TIMEOUT_EN
            tmo_q      <= tmo_d;
`endif
        end
    end

    // Probe and arm sampling plus configuration storage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            probe_q <= '0;
            arm_q   <= 1'b0;
            for (int unsigned k = 0; k < STAGES; k++) begin
                mask_q[k]  <= '0;
                value_q[k] <= '0;
                count_q[k] <= '0;
`ifdef CWC_TRIG_TIMEOUT_EN
                tmo_lim_q[k] <= '0;
`endif
            end
        end else begin
            probe_q <= probe;
            arm_q   <= arm;
            for (int unsigned k = 0; k < STAGES; k++) begin
                mask_q[k]  <= mask_d[k];
                value_q[k] <= value_d[k];
                count_q[k] <= count_d[k];
`ifdef CWC_TRIG_TIMEOUT_EN
                tmo_lim_q[k] <= tmo_lim_d[k];
`endif
            end
        end
    end

    assign trig_out = trig_out_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign stage    = stage_q;

endmodule

// File: tb/tb_cwc_trig_seq.sv
// Directed bench for cwc_trig_seq, built with two stages on an 8-bit probe. Where a scenario
// needs only one real stage, stage 0 is programmed as a pass-through (mask 0, count 0).
module tb_cwc_trig_seq;
    import cwc_trig_pkg::*;

    localparam int unsigned DW     = 8;
    localparam int unsigned STAGES = 2;
    localparam int unsigned CNT_W  = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [DW-1:0] probe = '0;
    logic          arm = 1'b0;
    logic          abort = 1'b0;
    logic          cfg_we = 1'b0;
    logic [2:0]    cfg_addr = '0;
    logic [31:0]   cfg_wdata = '0;
    logic          trig_out;
    logic          busy;
    logic          done;
    logic [0:0]    stage;

    int checks = 0;
    int errors = 0;

    cwc_trig_seq #(
        .DW    (DW),
        .STAGES(STAGES),
        .CNT_W (CNT_W)
    ) u_dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .probe    (probe),
        .arm      (arm),
        .abort    (abort),
        .cfg_we   (cfg_we),
        .cfg_addr (cfg_addr),
        .cfg_wdata(cfg_wdata),
        .trig_out (trig_out),
        .busy     (busy),
        .done     (done),
        .stage    (stage)
    );

    always #5 clk = ~clk;

    // Advance one clock; inputs change and outputs are read 1ns after the rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_write(input logic stg, input logic [1:0] sel, input logic [31:0] data);
        cfg_we    = 1'b1;
        cfg_addr  = {stg, sel};
        cfg_wdata = data;
        step();
        cfg_we    = 1'b0;
    endtask

    task automatic test_reset();
        #3;
        checks++; if (trig_out !== 1'b0) begin errors++; $display("FAIL reset_trig got %b want 0", trig_out); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
        checks++; if (stage !== 1'b0) begin errors++; $display("FAIL reset_stage got %0d want 0", stage); end
        #9 rst_n = 1'b1;
        step();
    endtask

    // Stage 1 needs three 0x5A samples (count 2); stage 0 passes straight through
    task automatic test_single_stage();
        cfg_write(1'b0, SEL_MASK, 32'h0);
        cfg_write(1'b0, SEL_COUNT, 32'h0);
        cfg_write(1'b1, SEL_MASK, 32'hFF);
        cfg_write(1'b1, SEL_VALUE, 32'h5A);
        cfg_write(1'b1, SEL_COUNT, 32'h2);
        probe = 8'h00;
        arm = 1'b1;
        step();
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy_rise got %b want 1", busy); end
        step();
        checks++; if (stage !== 1'b1) begin errors++; $display("FAIL single_stage1 got %0d want 1", stage); end
        for (int i = 0; i < 3; i++) begin
            probe = 8'h5A;
            step();
            probe = 8'h00;
            checks++; if (trig_out !== 1'b0) begin errors++; $display("FAIL single_early_trig%0d got %b want 0", i, trig_out); end
            if (i < 2) step();
        end
        // Third match sampled; pulse appears one edge later and lasts one cycle
        step();
        checks++; if (trig_out !== 1'b1) begin errors++; $display("FAIL single_trig got %b want 1", trig_out); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy_fall got %b want 0", busy); end
        step();
        checks++; if (trig_out !== 1'b0) begin errors++; $display("FAIL single_trig_width got %b want 0", trig_out); end
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL single_done got %b want 1", done); end
        // arm still held high: no re-arm
        step();
        step();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_no_rearm got %b want 0", busy); end
        arm = 1'b0;
        step();
    endtask

    task automatic test_two_stage();
        cfg_write(1'b0, SEL_MASK, 32'h1);
        cfg_write(1'b0, SEL_VALUE, 32'h1);
        cfg_write(1'b0, SEL_COUNT, 32'h0);
        cfg_write(1'b1, SEL_MASK, 32'h2);
        cfg_write(1'b1, SEL_VALUE, 32'h2);
        cfg_write(1'b1, SEL_COUNT, 32'h0);
        probe = 8'h00;
        arm = 1'b1;
        step();
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL two_done_clear got %b want 0", done); end
        probe = 8'h02;
        step();
        step();
        checks++; if (stage !== 1'b0) begin errors++; $display("FAIL two_wrong_order_stage got %0d want 0", stage); end
        checks++; if (trig_out !== 1'b0) begin errors++; $display("FAIL two_wrong_order_trig got %b want 0", trig_out); end
        probe = 8'h01;
        step();
        checks++; if (stage !== 1'b0) begin errors++; $display("FAIL two_stage_hold got %0d want 0", stage); end
        step();
        checks++; if (stage !== 1'b1) begin errors++; $display("FAIL two_stage_adv got %0d want 1", stage); end
        probe = 8'h02;
        step();
        checks++; if (trig_out !== 1'b0) begin errors++; $display("FAIL two_pre_trig got %b want 0", trig_out); end
        step();
        checks++; if (trig_out !== 1'b1) begin errors++; $display("FAIL two_trig got %b want 1", trig_out); end
        step();
        checks++; if (stage !== 1'b0) begin errors++; $display("FAIL two_stage_back got %0d want 0", stage); end
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL two_done got %b want 1", done); end
        arm = 1'b0;
        probe = 8'h00;
        step();
    endtask

    task automatic test_abort();
        arm = 1'b1;
        probe = 8'h01;
        step();
        step();
        checks++; if (stage !== 1'b1) begin errors++; $display("FAIL abort_setup_stage got %0d want 1", stage); end
        probe = 8'h00;
        abort = 1'b1;
        step();
        abort = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy got %b want 0", busy); end
        checks++; if (stage !== 1'b0) begin errors++; $display("FAIL abort_stage got %0d want 0", stage); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL abort_done got %b want 0", done); end
        probe = 8'h02;
        step();
        step();
        checks++; if (trig_out !== 1'b0) begin errors++; $display("FAIL abort_no_trig got %b want 0", trig_out); end
        arm = 1'b0;
        probe = 8'h00;
        step();
        // Abort together with an arm edge: edge is consumed, block stays idle
        arm = 1'b1;
        abort = 1'b1;
        step();
        abort = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_arm_busy got %b want 0", busy); end
        step();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_arm_consumed got %b want 0", busy); end
        arm = 1'b0;
        step();
    endtask

    task automatic test_cfg_in_run();
        cfg_write(1'b0, SEL_MASK, 32'h0);
        cfg_write(1'b1, SEL_MASK, 32'hFF);
        cfg_write(1'b1, SEL_VALUE, 32'hA5);
        cfg_write(1'b1, SEL_COUNT, 32'h0);
        arm = 1'b1;
        step();
        step();
        cfg_write(1'b1, SEL_COUNT, 32'h5);
        probe = 8'hA5;
        step();
        probe = 8'h00;
        step();
        checks++; if (trig_out !== 1'b1) begin errors++; $display("FAIL cfg_run_ignored got %b want 1", trig_out); end
        arm = 1'b0;
        step();
        cfg_write(1'b1, SEL_COUNT, 32'h5);
        arm = 1'b1;
        step();
        step();
        for (int i = 0; i < 6; i++) begin
            probe = 8'hA5;
            step();
            probe = 8'h00;
            step();
            checks++;
            if (trig_out !== (i == 5)) begin
                errors++;
                $display("FAIL cfg_idle_match%0d got %b want %b", i, trig_out, (i == 5));
            end
        end
        arm = 1'b0;
        step();
    endtask

    task automatic test_timeout();
        logic [0:0] exp_stage;
`ifdef CWC_TRIG_TIMEOUT_EN
        exp_stage = 1'b0;
`else
        exp_stage = 1'b1;
`endif
        cfg_write(1'b1, SEL_COUNT, 32'h0);
        cfg_write(1'b1, SEL_TMO, 32'h4);
        probe = 8'h00;
        arm = 1'b1;
        step();
        step();
        step();
        step();
        step();
        checks++; if (stage !== 1'b1) begin errors++; $display("FAIL tmo_before got %0d want 1", stage); end
        step();
        checks++; if (stage !== exp_stage) begin errors++; $display("FAIL tmo_stage got %0d want %0d", stage, exp_stage); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL tmo_busy got %b want 1", busy); end
        checks++; if (trig_out !== 1'b0) begin errors++; $display("FAIL tmo_trig got %b want 0", trig_out); end
        abort = 1'b1;
        step();
        abort = 1'b0;
        arm = 1'b0;
        cfg_write(1'b1, SEL_TMO, 32'h0);
    endtask

    task automatic test_reset_mid();
        arm = 1'b1;
        step();
        step();
        checks++; if (stage !== 1'b1) begin errors++; $display("FAIL rst_setup_stage got %0d want 1", stage); end
        rst_n = 1'b0;
        arm = 1'b0;
        #2;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy got %b want 0", busy); end
        checks++; if (stage !== 1'b0) begin errors++; $display("FAIL rst_mid_stage got %0d want 0", stage); end
        checks++; if (trig_out !== 1'b0) begin errors++; $display("FAIL rst_mid_trig got %b want 0", trig_out); end
        #2 rst_n = 1'b1;
        step();
        step();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_needs_edge got %b want 0", busy); end
        // Config is back to zero, so both stages match immediately
        probe = 8'h33;
        arm = 1'b1;
        step();
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rst_rearm_busy got %b want 1", busy); end
        step();
        checks++; if (trig_out !== 1'b0) begin errors++; $display("FAIL rst_pre_trig got %b want 0", trig_out); end
        step();
        checks++; if (trig_out !== 1'b1) begin errors++; $display("FAIL rst_cfg_zero_trig got %b want 1", trig_out); end
        arm = 1'b0;
        step();
    endtask

    initial begin
        test_reset();
        test_single_stage();
        test_two_stage();
        test_abort();
        test_cfg_in_run();
        test_timeout();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired: bench did not complete");
        $fatal(1);
    end

endmodule
